instruction_fetch: RTL and testbench

Fetch stage between the program counter and decode. Holds the fetch PC, issues in-order word reads to instruction memory over a valid/ready request channel, and buffers the returned words with their PCs in a small FIFO. It presents each buffered instruction to decode over a valid/ready handshake. It also applies redirects from branch/jump resolution and discards any in-flight responses that were fetched down the wrong path.

---
 rtl/instruction_fetch.sv | 97 +++++++++
 tb/tb_instruction_fetch.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch PC, in-order memory read requests and a small {pc, data} buffer toward decode.
// Redirects clear the buffer and drain wrong-path responses before fetching resumes.
module instruction_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] fetch_pc, target;
  logic [CW-1:0] outstanding, drop, count, out_next;
  logic [ADDR_WIDTH-1:0] pc_q [DEPTH];
  logic [ADDR_WIDTH-1:0] tag_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, tag_rd, tag_wr;
  logic req_fire, rsp_keep, pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // Requests plus buffered words never exceed DEPTH, so every response has a free slot.
  assign mem_req_valid = state == FETCH && ({1'b0, outstanding} + {1'b0, count} < (CW + 1)'(DEPTH));
  assign mem_req_addr = fetch_pc;
  assign inst_valid = count != '0;
  assign inst_data = inst_valid ? data_q[rd_ptr] : '0;
  assign inst_pc = inst_valid ? pc_q[rd_ptr] : '0;
  assign req_fire = mem_req_valid && mem_req_ready;
  assign pop = inst_valid && inst_ready;
  assign rsp_keep = state == FETCH && mem_rsp_valid && !redirect_valid;
  assign out_next = outstanding + CW'(req_fire) - CW'(mem_rsp_valid);
  assign target = redirect_pc & ~ADDR_WIDTH'(3);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      outstanding <= '0;
      drop <= '0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      tag_rd <= '0;
      tag_wr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i] <= '0;
        tag_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      outstanding <= out_next;
      count <= count + CW'(rsp_keep) - CW'(pop);
      if (req_fire) begin
        tag_q[tag_wr] <= fetch_pc;
        tag_wr <= inc(tag_wr);
        fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
      end
      if (rsp_keep) begin
        pc_q[wr_ptr] <= tag_q[tag_rd];
        data_q[wr_ptr] <= mem_rsp_data;
        wr_ptr <= inc(wr_ptr);
        tag_rd <= inc(tag_rd);
      end
      if (pop) rd_ptr <= inc(rd_ptr);
      // Redirect overrides everything above; every request still in flight becomes one to drop.
      if (redirect_valid) begin
        fetch_pc <= target;
        count <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        tag_rd <= '0;
        tag_wr <= '0;
        drop <= out_next;
        state <= out_next != '0 ? FLUSH : FETCH;
      end else if (state == IDLE) begin
        state <= FETCH;
      end else if (state == FLUSH && mem_rsp_valid) begin
        drop <= drop - 1'b1;
        if (drop == CW'(1)) state <= FETCH;
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenarios plus random traffic against a queue-based transaction model.
module tb_instruction_fetch;
  logic clk = 0, reset = 0, redirect_valid = 0, mem_req_ready = 0, mem_rsp_valid = 0, inst_ready = 0;
  logic [31:0] redirect_pc = 0, mem_rsp_data = 0;
  logic mem_req_valid, inst_valid;
  logic [31:0] mem_req_addr, inst_data, inst_pc;
  always #5 clk = ~clk;
  instruction_fetch dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
  );
  typedef struct {logic [31:0] pc; bit stale;} fl_t;
  typedef struct {logic [31:0] pc; logic [31:0] data;} ent_t;
  typedef struct {logic [31:0] addr; int due;} mreq_t;
  fl_t inflight[$];
  ent_t buffer[$];
  ent_t dlv[$];
  mreq_t mq[$];
  logic [31:0] acc[$];
  logic [31:0] m_pc = 0;
  bit started = 0;
  int cyc = 0, vectors = 0, miscompares = 0, lat_lo = 1, lat_hi = 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic bit flushing();
    foreach (inflight[i]) if (inflight[i].stale) return 1;
    return 0;
  endfunction
  function automatic bit rsp_due();
    return mq.size() != 0 && mq[0].due <= cyc;
  endfunction
  task automatic cycle(input bit rr, input bit ir, input bit rv, input logic [31:0] rpc);
    bit ev, pop, s_valid;
    logic [31:0] s_addr;
    fl_t f;
    @(negedge clk);
    mem_req_ready = rr;
    inst_ready = ir;
    redirect_valid = rv;
    redirect_pc = rpc;
    mem_rsp_valid = rsp_due();
    mem_rsp_data = mem_rsp_valid ? mq[0].addr ^ 32'hFFFF : 32'h0;
    #1;
    ev = started && !flushing() && (inflight.size() + buffer.size() < 2);
    pop = buffer.size() != 0 && ir;
    chk("req_valid", {31'b0, mem_req_valid}, {31'b0, ev});
    chk("req_addr", mem_req_addr, m_pc);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, buffer.size() != 0});
    chk("inst_pc", inst_pc, buffer.size() != 0 ? buffer[0].pc : 32'h0);
    chk("inst_data", inst_data, buffer.size() != 0 ? buffer[0].data : 32'h0);
    s_valid = mem_req_valid;
    s_addr = mem_req_addr;
    if (inst_valid && ir) dlv.push_back('{inst_pc, inst_data});
    @(posedge clk);
    cyc++;
    if (s_valid && rr) begin
      acc.push_back(s_addr);
      mq.push_back('{s_addr, cyc + $urandom_range(lat_hi, lat_lo) - 1});
    end
    if (mem_rsp_valid) mq.pop_front();
    if (pop) buffer.pop_front();
    if (mem_rsp_valid && inflight.size() != 0) begin
      f = inflight.pop_front();
      if (!rv && !f.stale) buffer.push_back('{f.pc, mem_rsp_data});
    end
    if (ev && rr) begin
      inflight.push_back('{m_pc, rv});
      m_pc = m_pc + 4;
    end
    if (rv) begin
      foreach (inflight[i]) inflight[i].stale = 1;
      buffer.delete();
      m_pc = {rpc[31:2], 2'b00};
    end
    if (reset) started = 1;
  endtask
  // Reset is asserted between edges so its effect on the outputs is seen before any clock.
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 0;
    #1;
    chk("rst_req_valid", {31'b0, mem_req_valid}, 32'h0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_req_addr", mem_req_addr, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_inst_data", inst_data, 32'h0);
    inflight.delete();
    buffer.delete();
    mq.delete();
    acc.delete();
    dlv.delete();
    m_pc = 0;
    started = 0;
    mem_rsp_valid = 0;
    redirect_valid = 0;
    @(posedge clk);
    #2 reset = 1;
  endtask
  initial begin
    int na, nd;
    bit hit;
    do_reset();
    repeat (8) cycle(1, 1, 0, 0);
    chk("t1_addr0", acc[0], 32'h0);
    chk("t1_addr1", acc[1], 32'h4);
    chk("t1_addr2", acc[2], 32'h8);
    chk("t1_pc0", dlv[0].pc, 32'h0);
    chk("t1_data0", dlv[0].data, 32'hFFFF);
    chk("t1_pc1", dlv[1].pc, 32'h4);
    do_reset();
    repeat (6) cycle(1, 0, 0, 0);
    #1;
    chk("t2_req_count", acc.size(), 2);
    chk("t2_valid_low", {31'b0, mem_req_valid}, 32'h0);
    repeat (4) cycle(0, 1, 0, 0);
    chk("t2_dlv0", dlv[0].pc, 32'h0);
    chk("t2_dlv1", dlv[1].pc, 32'h4);
    chk("t3_no_dup", acc.size(), 2);
    cycle(1, 1, 0, 0);
    chk("t3_once", acc.size(), 3);
    chk("t3_addr", acc[2], 32'h8);
    do_reset();
    lat_lo = 3;
    lat_hi = 3;
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 1, 32'h0F0F);
    na = acc.size();
    nd = dlv.size();
    repeat (12) cycle(1, 1, 0, 0);
    chk("t4_addr", acc[na], 32'h0F0C);
    chk("t4_pc", dlv[nd].pc, 32'h0F0C);
    chk("t4_data", dlv[nd].data, 32'h0F0C ^ 32'hFFFF);
    lat_lo = 1;
    lat_hi = 1;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      hit = rsp_due() && buffer.size() != 0;
      cycle(1, 1, hit, 32'h100);
    end
    nd = dlv.size();
    repeat (8) cycle(1, 1, 0, 0);
    chk("t5_pc", dlv[nd].pc, 32'h100);
    repeat (5) cycle(1, 1, 0, 0);
    do_reset();
    repeat (3) cycle(1, 1, 0, 0);
    chk("t6_restart", acc[0], 32'h0);
    lat_hi = 3;
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(3) != 0, $urandom_range(9) < 7, $urandom_range(19) == 0, $urandom);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
